seven_seg_display_arbiter: RTL and testbench

//  Shares the single 8-digit seven-segment display between NUM_REQ requesters.
//  - Round-robin arbitration with a minimum dwell time per grant, so digits never flicker between sources.
//  - Sends the winning 32-bit nibble-packed value to seven_segment_controller.val_in.
//  - Sits between the audio/pitch pipeline debug taps and the display driver.

---
 rtl/seven_seg_display_arbiter_if.sv | 25 ++
 rtl/seven_seg_display_arbiter.sv | 135 +++++++++++++
 tb/tb_seven_seg_display_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_display_arbiter_if.sv
// Bus between the display requesters and the seven-segment display arbiter.
// The master side owns requests, values and update strobes; the slave side
// (the arbiter) returns the grant and the value forwarded to the display.
interface seven_seg_display_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_in;
    logic [32*NUM_REQ-1:0]      val_in;
    logic [NUM_REQ-1:0]         upd_in;
    logic [NUM_REQ-1:0]         grant_out;
    logic [$clog2(NUM_REQ)-1:0] owner_out;
    logic                       active_out;
    logic [31:0]                val_out;
    logic                       switch_out;

    modport master (
        output req_in, val_in, upd_in,
        input  grant_out, owner_out, active_out, val_out, switch_out
    );

    modport slave (
        input  req_in, val_in, upd_in,
        output grant_out, owner_out, active_out, val_out, switch_out
    );
endinterface

// File: rtl/seven_seg_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display between
// NUM_REQ requesters. Each grant is held for at least HOLD_CYCLES cycles so
// the digits never flicker between sources; after that the display rotates
// to the next requester directly, or falls back to IDLE_VAL when nobody asks.
module seven_seg_display_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter logic [31:0] IDLE_VAL    = 32'h0000_0000
) (
    input logic clk_in,
    input logic rst_n_in,
    seven_seg_display_arbiter_if.slave bus
);
    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t             state_q, state_d;
    logic [OW-1:0]      last_q, last_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      hold_q, hold_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [31:0]        val_q, val_d;
    logic               switch_q, switch_d;

    logic [31:0]        vals [NUM_REQ];
    logic [NUM_REQ-1:0] cand;
    logic [OW-1:0]      rr_base;
    logic [OW-1:0]      idx;
    logic [OW-1:0]      pick;
    logic               pick_ok;
    logic               expired;

    // Unpack the flat value bus into one word per requester.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            vals[i] = bus.val_in[32*i +: 32];
        end
    end

    // Round-robin search starting after rr_base; in SHOW the current owner is
    // masked out, so the base is the owner itself rather than last_owner.
    always_comb begin
        cand    = (state_q == IDLE) ? bus.req_in : (bus.req_in & ~grant_q);
        rr_base = (state_q == IDLE) ? last_q : owner_q;
        idx     = '0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = OW'((32'(rr_base) + i) % NUM_REQ);
            if (!pick_ok && cand[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic of the IDLE/SHOW controller.
    always_comb begin
        expired  = (hold_q == HOLD_MAX);
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        hold_d   = hold_q;
        grant_d  = grant_q;
        val_d    = val_q;
        switch_d = 1'b0;
        case (state_q)
            IDLE: begin
                val_d = IDLE_VAL;
                if (pick_ok) begin
                    state_d  = SHOW;
                    owner_d  = pick;
                    grant_d  = NUM_REQ'(1) << pick;
                    val_d    = vals[pick];
                    switch_d = 1'b1;
                    hold_d   = '0;
                end
            end
            SHOW: begin
                if (!expired) begin
                    hold_d = hold_q + 1'b1;
                    if (bus.upd_in[owner_q]) val_d = vals[owner_q];
                end else if (pick_ok) begin
                    // A switch overrides a same-cycle owner update.
                    owner_d  = pick;
                    grant_d  = NUM_REQ'(1) << pick;
                    val_d    = vals[pick];
                    switch_d = 1'b1;
                    hold_d   = '0;
                    last_d   = owner_q;
                end else if (bus.req_in[owner_q]) begin
                    if (bus.upd_in[owner_q]) val_d = vals[owner_q];
                end else begin
                    state_d = IDLE;
                    owner_d = '0;
                    grant_d = '0;
                    val_d   = IDLE_VAL;
                    hold_d  = '0;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            last_q   <= OW'(NUM_REQ - 1);
            owner_q  <= '0;
            hold_q   <= '0;
            grant_q  <= '0;
            val_q    <= IDLE_VAL;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            grant_q  <= grant_d;
            val_q    <= val_d;
            switch_q <= switch_d;
        end
    end

    assign bus.grant_out  = grant_q;
    assign bus.owner_out  = owner_q;
    assign bus.active_out = (state_q == SHOW);
    assign bus.val_out    = val_q;
    assign bus.switch_out = switch_q;
endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Self-checking bench for seven_seg_display_arbiter (NUM_REQ=4, HOLD_CYCLES=4).
module tb_seven_seg_display_arbiter;
    localparam int unsigned NR   = 4;
    localparam int unsigned HOLD = 4;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;

    always #5 clk_in = ~clk_in;

    seven_seg_display_arbiter_if #(.NUM_REQ(NR)) bus ();

    seven_seg_display_arbiter #(
        .NUM_REQ     (NR),
        .HOLD_CYCLES (HOLD),
        .IDLE_VAL    (32'h0000_0000)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   upd;
        logic [127:0] vals;
        logic [3:0]   g;
        logic [31:0]  v;
        logic         sw;
    } vec_t;

    vec_t tbl [15];

    // Reference model: who owns the display, since which cycle, and what it shows.
    int          m_owner;
    int          m_last;
    int          m_cyc;
    int          m_grant_cyc;
    logic [31:0] m_val;
    logic        m_sw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] g, input logic [31:0] v, input logic sw);
        logic [1:0] own;
        own = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) own = 2'(i);
        check({name, ".grant"},  32'(bus.grant_out),  32'(g));
        check({name, ".owner"},  32'(bus.owner_out),  32'(own));
        check({name, ".active"}, 32'(bus.active_out), 32'(|g));
        check({name, ".val"},    bus.val_out,         v);
        check({name, ".switch"}, 32'(bus.switch_out), 32'(sw));
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] upd, input logic [127:0] vals);
        bus.req_in = req;
        bus.upd_in = upd;
        bus.val_in = vals;
    endtask

    task automatic do_reset();
        drive(4'h0, 4'h0, '0);
        rst_n_in = 1'b0;
        tick();
        tick();
        rst_n_in = 1'b1;
        m_owner = -1;
        m_last  = NR - 1;
        m_cyc   = 0;
        m_val   = 32'h0;
        m_sw    = 1'b0;
    endtask

    function automatic int rr_pick(input int after, input logic [3:0] mask);
        for (int k = 1; k <= NR; k++) begin
            if (mask[(after + k) % NR]) return (after + k) % NR;
        end
        return -1;
    endfunction

    // One clock of the model; the display age is measured from the grant cycle.
    task automatic model_step(input logic [3:0] req, input logic [3:0] upd, input logic [127:0] vals);
        int w;
        m_sw = 1'b0;
        if (m_owner < 0) begin
            w = rr_pick(m_last, req);
            if (w >= 0) begin
                m_owner = w; m_val = vals[32*w +: 32]; m_sw = 1'b1; m_grant_cyc = m_cyc + 1;
            end
        end else if (m_cyc - m_grant_cyc < int'(HOLD) - 1) begin
            if (upd[m_owner]) m_val = vals[32*m_owner +: 32];
        end else begin
            w = rr_pick(m_owner, req & ~(4'b1 << m_owner));
            if (w >= 0) begin
                m_last = m_owner; m_owner = w; m_val = vals[32*w +: 32]; m_sw = 1'b1;
                m_grant_cyc = m_cyc + 1;
            end else if (req[m_owner]) begin
                if (upd[m_owner]) m_val = vals[32*m_owner +: 32];
            end else begin
                m_last = m_owner; m_owner = -1; m_val = 32'h0;
            end
        end
        m_cyc++;
    endtask

    initial begin
        logic [127:0] va, vb, vc, rv;
        logic [3:0]   rq, up;
        int           waited;

        va = {32'h5555_5555, 32'h0000_1234, 32'h0000_0001, 32'h1111_0000};
        vb = {32'h5555_5555, 32'h0000_1234, 32'hDEAD_BEEF, 32'h1111_0000};
        vc = {32'h5555_5555, 32'h0000_1234, 32'h0BAD_F00D, 32'h1111_0000};

        // Single requester dwell, owner updates, non-owner update, expiry switch.
        tbl[0]  = '{4'b0100, 4'b0000, va, 4'b0100, 32'h0000_1234, 1'b1};
        tbl[1]  = '{4'b0000, 4'b0000, va, 4'b0100, 32'h0000_1234, 1'b0};
        tbl[2]  = '{4'b0000, 4'b0000, va, 4'b0100, 32'h0000_1234, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, va, 4'b0100, 32'h0000_1234, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, va, 4'b0000, 32'h0000_0000, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, va, 4'b0000, 32'h0000_0000, 1'b0};
        tbl[6]  = '{4'b0010, 4'b0000, va, 4'b0010, 32'h0000_0001, 1'b1};
        tbl[7]  = '{4'b0010, 4'b0010, vb, 4'b0010, 32'hDEAD_BEEF, 1'b0};
        tbl[8]  = '{4'b1010, 4'b1000, vc, 4'b0010, 32'hDEAD_BEEF, 1'b0};
        tbl[9]  = '{4'b1010, 4'b0000, vc, 4'b0010, 32'hDEAD_BEEF, 1'b0};
        tbl[10] = '{4'b1010, 4'b0010, vc, 4'b1000, 32'h5555_5555, 1'b1};
        tbl[11] = '{4'b0000, 4'b0000, vc, 4'b1000, 32'h5555_5555, 1'b0};
        tbl[12] = '{4'b0000, 4'b0000, vc, 4'b1000, 32'h5555_5555, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, vc, 4'b1000, 32'h5555_5555, 1'b0};
        tbl[14] = '{4'b0000, 4'b0000, vc, 4'b0000, 32'h0000_0000, 1'b0};

        do_reset();
        check_outs("reset", 4'b0000, 32'h0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].req, tbl[i].upd, tbl[i].vals);
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].g, tbl[i].v, tbl[i].sw);
        end

        // Asynchronous reset in the middle of a SHOW dwell.
        drive(4'b0001, 4'b0000, va);
        tick();
        check_outs("pre_async", 4'b0001, 32'h1111_0000, 1'b1);
        #3;
        rst_n_in = 1'b0;
        #1;
        check_outs("async_rst", 4'b0000, 32'h0, 1'b0);
        do_reset();

        // Full load: 0,1,2,3,0, each exactly HOLD cycles, no idle gap.
        drive(4'b1111, 4'b0000, va);
        for (int k = 0; k < 20; k++) begin
            tick();
            check_outs($sformatf("rot%0d", k), 4'b1 << ((k / 4) % 4),
                       va[32*((k / 4) % 4) +: 32], (k % 4) == 0);
        end
        drive(4'b0000, 4'b0000, va);
        waited = 0;
        while (bus.active_out && waited < 20) begin
            tick();
            waited++;
        end
        check("idle_wait", 32'(bus.active_out), 32'h0);

        // Sole owner held beyond the dwell, then another requester arrives.
        drive(4'b0001, 4'b0000, va);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_outs($sformatf("hold%0d", k), 4'b0001, 32'h1111_0000, k == 0);
        end
        drive(4'b0101, 4'b0000, va);
        tick();
        check_outs("late_req", 4'b0100, 32'h0000_1234, 1'b1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            rq = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            up = 4'($urandom);
            rv = {$urandom, $urandom, $urandom, $urandom};
            drive(rq, up, rv);
            @(posedge clk_in);
            model_step(rq, up, rv);
            #1;
            check_outs($sformatf("rnd%0d", n), (m_owner < 0) ? 4'b0 : (4'b1 << m_owner), m_val, m_sw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
